// File: rtl/audio_synth_pkg.sv
// Shared types and constants for the audio synth PWM path and its receive-side demodulator.
package audio_synth_pkg;

    localparam int SAMPLE_W = 8;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } demod_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer for an asynchronous PWM input plus rising-edge detect on the
// synchronized level.
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic pwm_i,
    output logic pwm_s_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_prev_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q     <= '0;
            pwm_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_i};
            pwm_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pwm_s_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = pwm_s_o & ~pwm_prev_q;

endmodule

// File: rtl/pwm_sample_demod.sv
// Recovers one WIDTH-bit sample per 2^WIDTH-cycle PWM frame, aligning frame phase on rising
// edges and reporting lock and phase violations.
module pwm_sample_demod
    import audio_synth_pkg::*;
#(
    parameter int WIDTH       = SAMPLE_W,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pwm_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             sample_valid_o,
    output logic             locked_o,
    output logic             frame_err_o,
    output logic [1:0]       state_o
);

    localparam int                GW         = $clog2(LOCK_FRAMES + 1);
    localparam logic [GW-1:0]     LOCK_LAST  = GW'(LOCK_FRAMES - 1);
    localparam logic [WIDTH-1:0]  FRAME_LAST = '1;

    logic pwm_s;
    logic rise;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .n_rst   (n_rst),
        .pwm_i   (pwm_i),
        .pwm_s_o (pwm_s),
        .rise_o  (rise)
    );

    demod_state_t     state_q,      state_d;
    logic [WIDTH-1:0] frame_cnt_q,  frame_cnt_d;
    logic [WIDTH:0]   high_cnt_q,   high_cnt_d;
    logic [GW-1:0]    good_cnt_q,   good_cnt_d;
    logic [WIDTH-1:0] sample_q,     sample_d;
    logic             valid_q,      valid_d;
    logic             locked_q,     locked_d;
    logic             err_q,        err_d;
    logic             err_pend_q,   err_pend_d;

    logic             frame_end;
    logic             mid_rise;
    logic [WIDTH:0]   high_total;

    assign frame_end  = (frame_cnt_q == FRAME_LAST);
    assign mid_rise   = rise && (frame_cnt_q != '0);
    assign high_total = high_cnt_q + {{WIDTH{1'b0}}, pwm_s};

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q + WIDTH'(1);
        high_cnt_d  = frame_end ? '0 : high_total;
        good_cnt_d  = good_cnt_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        err_d       = err_pend_q;
        err_pend_d  = 1'b0;

        case (state_q)
            HUNT: begin
                frame_cnt_d = '0;
                high_cnt_d  = '0;
                good_cnt_d  = '0;
                if (rise) begin
                    // The edge cycle itself is frame index 0.
                    frame_cnt_d = WIDTH'(1);
                    high_cnt_d  = (WIDTH+1)'(1);
                    state_d     = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (mid_rise) begin
                    frame_cnt_d = WIDTH'(1);
                    high_cnt_d  = (WIDTH+1)'(1);
                    good_cnt_d  = '0;
                end else if (frame_end) begin
                    if (good_cnt_q == LOCK_LAST) begin
                        state_d = LOCKED;
                    end else begin
                        good_cnt_d = good_cnt_q + GW'(1);
                    end
                end
            end
            LOCKED: begin
                if (frame_end) begin
                    sample_d = high_total[WIDTH] ? '1 : high_total[WIDTH-1:0];
                    valid_d  = 1'b1;
                end
                if (mid_rise) begin
                    frame_cnt_d = WIDTH'(1);
                    high_cnt_d  = (WIDTH+1)'(1);
                    good_cnt_d  = '0;
                    state_d     = ACQUIRE;
                    // A violation on the frame-end cycle is reported one cycle after the sample.
                    if (frame_end) begin
                        err_pend_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (!enable_i) begin
            state_d     = HUNT;
            frame_cnt_d = '0;
            high_cnt_d  = '0;
            good_cnt_d  = '0;
            sample_d    = sample_q;
            valid_d     = 1'b0;
            err_d       = 1'b0;
            err_pend_d  = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= HUNT;
            frame_cnt_q <= '0;
            high_cnt_q  <= '0;
            good_cnt_q  <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            high_cnt_q  <= high_cnt_d;
            good_cnt_q  <= good_cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            err_pend_q  <= err_pend_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign locked_o       = locked_q;
    assign frame_err_o    = err_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_pwm_sample_demod.sv
// Bench for pwm_sample_demod: a bench-side PWM generator drives frames and pushes each expected
// sample; a monitor pops and compares on every sample_valid_o pulse.
module tb_pwm_sample_demod;
    import audio_synth_pkg::*;

    localparam int W     = 8;
    localparam int FRAME = 1 << W;
    localparam int SYNC  = 2;
    localparam int LOCKF = 2;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         pwm_i = 1'b0;
    logic         enable_i = 1'b1;
    logic [W-1:0] sample_o;
    logic         sample_valid_o;
    logic         locked_o;
    logic         frame_err_o;
    logic [1:0]   state_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int last_valid_cyc = 0;
    int last_gap = 0;

    logic [W-1:0] exp_q[$];

    pwm_sample_demod #(
        .WIDTH(W),
        .SYNC_STAGES(SYNC),
        .LOCK_FRAMES(LOCKF)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .pwm_i          (pwm_i),
        .enable_i       (enable_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .locked_o       (locked_o),
        .frame_err_o    (frame_err_o),
        .state_o        (state_o)
    );

    // clock / reset / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] sat(input int h);
        if (h >= FRAME) return {W{1'b1}};
        return W'(h);
    endfunction

    // scoreboard monitor
    always @(posedge clk) begin
        #2;
        cyc++;
        if (sample_valid_o && frame_err_o) begin
            checks++;
            failures++;
            $display("FAIL pulse_overlap: valid=1 err=1 at cycle %0d, required never both", cyc);
        end
        if (frame_err_o) err_cnt++;
        if (sample_valid_o) begin
            valid_cnt++;
            last_gap = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: sample=%0d at cycle %0d, required no valid", sample_o, cyc);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (sample_o !== e) begin
                    failures++;
                    $display("FAIL sample: got %0d required %0d at cycle %0d", sample_o, e, cyc);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_frame(input int high, input bit expect_smp);
        if (expect_smp) exp_q.push_back(sat(high));
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            pwm_i = (i < high);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pwm_i = 1'b0;
        end
    endtask

    // tests
    task automatic test_reset;
        n_rst = 1'b0;
        idle(4);
        checks++;
        if (sample_o !== '0 || sample_valid_o !== 1'b0 || locked_o !== 1'b0 ||
            frame_err_o !== 1'b0 || state_o !== 2'(HUNT)) begin
            failures++;
            $display("FAIL reset_state: sample=%0d valid=%b locked=%b err=%b state=%0d, required all 0",
                     sample_o, sample_valid_o, locked_o, frame_err_o, state_o);
        end
        n_rst = 1'b1;
        idle(10);
        checks++;
        if (state_o !== 2'(HUNT) || locked_o !== 1'b0) begin
            failures++;
            $display("FAIL hunt_idle: state=%0d locked=%b, required HUNT/0", state_o, locked_o);
        end
    endtask

    task automatic test_lock;
        int v0;
        int e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        drive_frame(128, 1'b0);
        checks++;
        if (locked_o !== 1'b0) begin
            failures++;
            $display("FAIL early_lock: locked=%b after 1 frame, required 0", locked_o);
        end
        for (int f = 1; f < LOCKF; f++) drive_frame(128, 1'b0);
        for (int f = 0; f < 6; f++) drive_frame(128, 1'b1);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL lock: locked=%b, required 1", locked_o);
        end
        checks++;
        if (valid_cnt - v0 != 5) begin
            failures++;
            $display("FAIL lock_valid_count: got %0d required 5", valid_cnt - v0);
        end
        checks++;
        if (last_gap != FRAME) begin
            failures++;
            $display("FAIL valid_period: got %0d required %0d", last_gap, FRAME);
        end
        checks++;
        if (err_cnt != e0) begin
            failures++;
            $display("FAIL lock_err: got %0d err pulses required 0", err_cnt - e0);
        end
    endtask

    task automatic test_values;
        int e0;
        e0 = err_cnt;
        drive_frame(0, 1'b1);
        drive_frame(255, 1'b1);
        drive_frame(FRAME, 1'b1);
        drive_frame(1, 1'b1);
        drive_frame(128, 1'b1);
        checks++;
        if (locked_o !== 1'b1 || err_cnt != e0) begin
            failures++;
            $display("FAIL values_lock: locked=%b errs=%0d, required 1/0", locked_o, err_cnt - e0);
        end
    endtask

    task automatic test_phase_error;
        int e0;
        e0 = err_cnt;
        // 37 cycles into a frame, then a rise starts the new phase
        for (int i = 0; i < 37; i++) begin
            @(negedge clk);
            pwm_i = (i < 20);
        end
        drive_frame(100, 1'b0);
        checks++;
        if (err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL frame_err: got %0d pulses required 1", err_cnt - e0);
        end
        checks++;
        if (locked_o !== 1'b0) begin
            failures++;
            $display("FAIL unlock_on_err: locked=%b required 0", locked_o);
        end
        for (int f = 1; f < LOCKF; f++) drive_frame(100, 1'b0);
        drive_frame(100, 1'b1);
        drive_frame(50, 1'b1);
        drive_frame(200, 1'b1);
        checks++;
        if (locked_o !== 1'b1 || err_cnt - e0 != 1) begin
            failures++;
            $display("FAIL relock: locked=%b errs=%0d, required 1/1", locked_o, err_cnt - e0);
        end
    endtask

    task automatic test_enable;
        drive_frame(77, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            pwm_i = (i < 77);
            enable_i = !(i >= 100 && i < 110);
        end
        checks++;
        if (locked_o !== 1'b0 || sample_o !== 8'd77) begin
            failures++;
            $display("FAIL enable_clear: locked=%b sample=%0d, required 0/77", locked_o, sample_o);
        end
        for (int f = 0; f < LOCKF; f++) drive_frame(200, 1'b0);
        checks++;
        if (sample_o !== 8'd77) begin
            failures++;
            $display("FAIL enable_hold: sample=%0d required 77", sample_o);
        end
        drive_frame(200, 1'b1);
        drive_frame(33, 1'b1);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL enable_relock: locked=%b required 1", locked_o);
        end
    endtask

    task automatic test_reset_midrun;
        int v0;
        bit bad;
        bad = 1'b0;
        drive_frame(90, 1'b1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            pwm_i = (i < 90) ^ (i >= 55 && i < 65 && i[0]);
            if (!n_rst && (sample_o !== '0 || sample_valid_o !== 1'b0 || locked_o !== 1'b0 ||
                           frame_err_o !== 1'b0 || state_o !== 2'(HUNT)))
                bad = 1'b1;
            if (i == 50) n_rst = 1'b0;
            if (i == 70) n_rst = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_midrun: outputs nonzero during reset, required all 0");
        end
        v0 = valid_cnt;
        for (int f = 0; f < LOCKF; f++) drive_frame(90, 1'b0);
        checks++;
        if (valid_cnt != v0 || sample_o !== '0) begin
            failures++;
            $display("FAIL post_reset_quiet: valids=%0d sample=%0d, required 0/0", valid_cnt - v0, sample_o);
        end
        drive_frame(45, 1'b1);
        drive_frame(250, 1'b1);
        checks++;
        if (locked_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_lock: locked=%b required 1", locked_o);
        end
    endtask

    task automatic test_loopback;
        for (int f = 0; f < 10; f++) drive_frame(int'($urandom_range(0, FRAME)), 1'b1);
        idle(3 * SYNC + 10);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d samples outstanding, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_values();
        test_phase_error();
        test_enable();
        test_reset_midrun();
        test_loopback();
        checks++;
        if (err_cnt != 1) begin
            failures++;
            $display("FAIL total_err: got %0d pulses required 1", err_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
